// File: rtl/down2x_pkg.sv
// Shared widths, sum-word type and rounding constant for the down2x decimator.
// Build option: DOWN2X_ROUND_EN selects round-half-up averaging instead of truncation.
package down2x_pkg;

    localparam int MAX_CW = 8;

    function automatic int CW(input int half_depth);
        if (half_depth != 0) begin
            return 4;
        end else begin
            return 8;
        end
    endfunction

    function automatic int DWIDTH(input int half_depth);
        return 3 * CW(half_depth) - 1;
    endfunction

    // Per-channel horizontal pair sums as stored in the line buffer, widest build.
    typedef struct packed {
        logic [MAX_CW:0] b;
        logic [MAX_CW:0] g;
        logic [MAX_CW:0] r;
    } sum_word_t;

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } row_t;

`ifdef DOWN2X_ROUND_EN
    localparam int unsigned RND = 32'd2;
`else
    localparam int unsigned RND = 32'd0;
`endif

endpackage

// File: rtl/down2x_linebuf.sv
// Simple dual-port line buffer of horizontal pair sums: one write port and
// a read port whose data register is refreshed every clock.
module down2x_linebuf
    import down2x_pkg::*;
#(
    parameter int AW    = 9,
    parameter int WIDTH = 27
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [0:(2**AW)-1];

    // Storage write; contents deliberately survive reset and frame start.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Registered read, one clock of latency.
    always_ff @(posedge clk) begin
        rdata <= r_mem[raddr];
    end

endmodule

// File: rtl/down2x.sv
// down2x: 2x2 box-filter video decimator emitting one averaged pixel per 2x2 block.
// Build option: DOWN2X_ROUND_EN adds a rounding term of 2 before the divide by four.
module down2x
    import down2x_pkg::*;
#(
    parameter int LENGTH     = 1024,
    parameter int HALF_DEPTH = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        ce_in,
    input  logic [DWIDTH(HALF_DEPTH):0] inputpixel,
    input  logic                        reset_line,
    input  logic                        reset_frame,
    output logic                        out_valid,
    output logic [DWIDTH(HALF_DEPTH):0] outpixel,
    output logic [$clog2(LENGTH)-2:0]   out_x
);

    localparam int C  = CW(HALF_DEPTH);
    localparam int AW = $clog2(LENGTH);
    localparam int BW = AW - 1;
    localparam int SW = 3 * (C + 1);
    localparam logic [C+1:0] RND_W = RND[C+1:0];

    logic [AW:0]         r_x;
    row_t                r_row;
    logic                r_prev_line;
    logic                r_prev_frame;
    logic                r_fresh;
    logic [3*C-1:0]      r_hold;
    logic [BW-1:0]       r_rd_addr;

    logic                w_line_start;
    logic                w_pix_ok;
    logic                w_even;
    logic                w_odd;
    logic                w_we;
    logic [AW:0]         w_cur_x;
    logic [BW-1:0]       w_col;
    logic [BW-1:0]       w_rd_addr;
    row_t                w_row_next;
    logic [2:0][C:0]     w_h;
    logic [2:0][C:0]     w_q;
    logic [2:0][C+1:0]   w_t;
    logic [3*C-1:0]      w_avg;
    logic                w_unused;

    // Line-start detection, column qualification and next row parity.
    always_comb begin
        w_line_start = ce_in & ~reset_line & r_prev_line;
        w_cur_x      = w_line_start ? {(AW+1){1'b0}} : r_x;
        w_pix_ok     = ce_in & ~reset_line & ~w_cur_x[AW];
        w_even       = w_pix_ok & ~w_cur_x[0];
        w_odd        = w_pix_ok & w_cur_x[0];
        w_col        = w_cur_x[AW-1:1];
        w_rd_addr    = w_even ? w_col : r_rd_addr;
        w_we         = w_odd & (r_row == ROW_EVEN);
        // r_fresh keeps the first line after reset EVEN even if blanking precedes it.
        if (!w_line_start) begin
            w_row_next = r_row;
        end else if (r_prev_frame | r_fresh) begin
            w_row_next = ROW_EVEN;
        end else begin
            w_row_next = (r_row == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
        end
    end

    // Per-channel pair sums and 2x2 average; the low two bits fall away in the divide.
    always_comb begin
        w_h   = {SW{1'b0}};
        w_t   = {(3*(C+2)){1'b0}};
        w_avg = {(3*C){1'b0}};
        for (int c = 0; c < 3; c++) begin
            w_h[c] = {1'b0, r_hold[c*C +: C]} + {1'b0, inputpixel[c*C +: C]};
            w_t[c] = {1'b0, w_h[c]} + {1'b0, w_q[c]} + RND_W;
            w_avg[c*C +: C] = w_t[c][C+1:2];
        end
        w_unused = ^{w_t[2][1:0], w_t[1][1:0], w_t[0][1:0]};
    end

    // Control state: input history, column counter, row parity, hold and read address.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_x          <= {(AW+1){1'b0}};
            r_row        <= ROW_EVEN;
            r_prev_line  <= 1'b1;
            r_prev_frame <= 1'b1;
            r_fresh      <= 1'b1;
            r_hold       <= {(3*C){1'b0}};
            r_rd_addr    <= {BW{1'b0}};
        end else begin
            if (ce_in) begin
                r_prev_line  <= reset_line;
                r_prev_frame <= reset_frame;
            end
            if (w_line_start) begin
                r_fresh <= 1'b0;
            end
            r_row <= w_row_next;
            if (w_pix_ok) begin
                r_x <= w_cur_x + {{AW{1'b0}}, 1'b1};
            end
            if (w_even) begin
                r_hold <= inputpixel;
            end
            r_rd_addr <= w_rd_addr;
        end
    end

    // Output register: pulse and pixel for each completed pair on an odd row.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            outpixel  <= {(3*C){1'b0}};
            out_x     <= {BW{1'b0}};
        end else begin
            out_valid <= w_odd & (r_row == ROW_ODD);
            if (w_odd & (r_row == ROW_ODD)) begin
                outpixel <= w_avg;
                out_x    <= w_col;
            end
        end
    end

    down2x_linebuf #(
        .AW    (BW),
        .WIDTH (SW)
    ) u_linebuf (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_col),
        .wdata (w_h),
        .raddr (w_rd_addr),
        .rdata (w_q)
    );

endmodule

// File: tb/tb_down2x.sv
// Scoreboard bench for down2x: a 24-bit and a 12-bit instance on shared video timing.
module tb_down2x;

    localparam int LEN = 16;
`ifdef DOWN2X_ROUND_EN
    localparam int RND = 2;
`else
    localparam int RND = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ce_in;
    logic        reset_line;
    logic        reset_frame;
    logic [23:0] pix0;
    logic [11:0] pix1;
    logic        ov0, ov1;
    logic [23:0] op0;
    logic [11:0] op1;
    logic [2:0]  ox0, ox1;

    down2x #(.LENGTH(LEN), .HALF_DEPTH(0)) u_dut (
        .clk(clk), .reset_n(rst_n), .ce_in(ce_in), .inputpixel(pix0),
        .reset_line(reset_line), .reset_frame(reset_frame),
        .out_valid(ov0), .outpixel(op0), .out_x(ox0)
    );

    down2x #(.LENGTH(LEN), .HALF_DEPTH(1)) u_dut_h (
        .clk(clk), .reset_n(rst_n), .ce_in(ce_in), .inputpixel(pix1),
        .reset_line(reset_line), .reset_frame(reset_frame),
        .out_valid(ov1), .outpixel(op1), .out_x(ox1)
    );

    typedef struct packed {
        logic [23:0] p;
        logic [2:0]  x;
    } exp_t;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   pulse_cyc[$];
    bit   en1 = 1'b0;
    int   cyc = 0;

    logic [23:0] line_pix [32];
    logic [23:0] m_up [32];
    bit          m_odd = 1'b0;
    bit          m_fresh = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every output pulse pops and checks the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ov0 === 1'b1) begin
            pulse_cyc.push_back(cyc);
            vectors++;
            if (q0.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_out: outpixel=%h out_x=%0d, required no pulse", op0, ox0);
            end else begin
                e = q0.pop_front();
                if ({op0, ox0} !== {e.p, e.x}) begin
                    miscompares++;
                    $display("FAIL out_pixel: got %h x=%0d, required %h x=%0d", op0, ox0, e.p, e.x);
                end
            end
        end
        if (en1 && ov1 === 1'b1) begin
            vectors++;
            if (q1.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_out_h: outpixel=%h, required no pulse", op1);
            end else begin
                e = q1.pop_front();
                if ({op1, ox1} !== {e.p[11:0], e.x}) begin
                    miscompares++;
                    $display("FAIL out_pixel_h: got %h x=%0d, required %h x=%0d", op1, ox1, e.p[11:0], e.x);
                end
            end
        end
    end

    function automatic logic [23:0] avg4(input logic [23:0] a, input logic [23:0] b,
                                         input logic [23:0] c, input logic [23:0] d);
        logic [9:0]  s;
        logic [23:0] r;
        r = 24'h0;
        for (int ch = 0; ch < 3; ch++) begin
            s = 10'(a[ch*8 +: 8]) + 10'(b[ch*8 +: 8]) + 10'(c[ch*8 +: 8]) + 10'(d[ch*8 +: 8]) + 10'(RND);
            r[ch*8 +: 8] = s[9:2];
        end
        return r;
    endfunction

    task automatic ce_cycle(input logic [23:0] p, input logic rl, input logic rf, input int gap);
        ce_in = 1'b1; pix0 = p; reset_line = rl; reset_frame = rf;
        @(posedge clk); #1;
        ce_in = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
        end
    endtask

    // Two blanking strobes then n pixels from line_pix; the model tracks row parity.
    task automatic send_line(input int n, input bit frame_blank, input int gap);
        ce_cycle(24'h0, 1'b1, frame_blank, gap);
        ce_cycle(24'h0, 1'b1, frame_blank, gap);
        m_odd = (frame_blank || m_fresh) ? 1'b0 : !m_odd;
        m_fresh = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i < LEN && (i % 2) == 1) begin
                if (m_odd) begin
                    q0.push_back({avg4(m_up[i-1], m_up[i], line_pix[i-1], line_pix[i]), 3'(i / 2)});
                    if (en1) q1.push_back({12'h000, 12'h123, 3'(i / 2)});
                end else begin
                    m_up[i-1] = line_pix[i-1];
                    m_up[i]   = line_pix[i];
                end
            end
            ce_cycle(line_pix[i], 1'b0, 1'b0, gap);
        end
    endtask

    task automatic check_drain(input string name, input int n0, input int pulses);
        repeat (3) @(negedge clk);
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d/%0d expected pixels never emitted, required 0", name, q0.size(), q1.size());
            q0.delete(); q1.delete();
        end
        vectors++;
        if (pulse_cyc.size() - n0 != pulses) begin
            miscompares++;
            $display("FAIL %s_pulses: got %0d out_valid pulses, required %0d", name, pulse_cyc.size() - n0, pulses);
        end
    endtask

    task automatic fill(input logic [23:0] v, input bit rnd);
        for (int i = 0; i < 32; i++) line_pix[i] = rnd ? 24'($urandom) : v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce_in = 1'b0; reset_line = 1'b1; reset_frame = 1'b1;
        pix0 = 24'h0; pix1 = 12'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({ov0, op0, ox0} !== 28'h0) begin
            miscompares++;
            $display("FAIL reset_out: valid=%b pixel=%h x=%0d, required all zero", ov0, op0, ox0);
        end
        vectors++;
        if ({ov1, op1, ox1} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_out_h: valid=%b pixel=%h x=%0d, required all zero", ov1, op1, ox1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_fresh = 1'b1;
    endtask

    task automatic test_flat();
        int n0;
        n0 = pulse_cyc.size();
        fill(24'h102030, 1'b0);
        send_line(4, 1'b1, 1);
        send_line(4, 1'b0, 1);
        check_drain("flat", n0, 2);
    endtask

    task automatic test_rounding();
        int n0;
        n0 = pulse_cyc.size();
        line_pix[0] = 24'h000000; line_pix[1] = 24'h000001;
        send_line(2, 1'b1, 0);
        line_pix[0] = 24'h000001; line_pix[1] = 24'h000001;
        send_line(2, 1'b0, 0);
        check_drain("rounding", n0, 1);
    endtask

    task automatic test_back_to_back();
        int n0;
        fill(24'hFFFFFF, 1'b0);
        send_line(8, 1'b1, 0);
        n0 = pulse_cyc.size();
        send_line(8, 1'b0, 0);
        check_drain("b2b", n0, 4);
        for (int k = n0 + 1; k < pulse_cyc.size(); k++) begin
            vectors++;
            if (pulse_cyc[k] - pulse_cyc[k-1] != 2) begin
                miscompares++;
                $display("FAIL b2b_spacing: pulse gap %0d clk, required 2", pulse_cyc[k] - pulse_cyc[k-1]);
            end
        end
    endtask

    task automatic test_line_len();
        int n0;
        n0 = pulse_cyc.size();
        fill(24'h0, 1'b1); send_line(5, 1'b1, 0);
        fill(24'h0, 1'b1); send_line(5, 1'b0, 2);
        check_drain("len5", n0, 2);
        n0 = pulse_cyc.size();
        fill(24'h0, 1'b1); send_line(4, 1'b1, 0);
        fill(24'h0, 1'b1); send_line(4, 1'b0, 0);
        check_drain("len5_after", n0, 2);
        n0 = pulse_cyc.size();
        fill(24'h0, 1'b1); send_line(18, 1'b1, 0);
        fill(24'h0, 1'b1); send_line(18, 1'b0, 0);
        check_drain("saturate", n0, LEN / 2);
    endtask

    task automatic test_frame_restart();
        int n0;
        n0 = pulse_cyc.size();
        fill(24'h0, 1'b1); send_line(4, 1'b1, 0);
        fill(24'h0, 1'b1); send_line(4, 1'b1, 0);
        check_drain("frame_even", n0, 0);
        n0 = pulse_cyc.size();
        fill(24'h0, 1'b1); send_line(4, 1'b0, 1);
        check_drain("frame_odd", n0, 2);
    endtask

    task automatic test_reset_mid();
        int n0;
        n0 = pulse_cyc.size();
        fill(24'h0, 1'b1); send_line(4, 1'b1, 0);
        fill(24'h0, 1'b1); send_line(3, 1'b0, 0);
        // the odd-x pixel of the second pair arrives together with reset
        ce_in = 1'b1; pix0 = line_pix[3]; reset_line = 1'b0; reset_frame = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; ce_in = 1'b0;
        m_fresh = 1'b1;
        vectors++;
        if ({ov0, op0, ox0} !== 28'h0) begin
            miscompares++;
            $display("FAIL reset_mid_out: valid=%b pixel=%h x=%0d, required all zero", ov0, op0, ox0);
        end
        check_drain("reset_mid_pre", n0, 1);
        n0 = pulse_cyc.size();
        fill(24'h0, 1'b1); send_line(4, 1'b0, 0);
        check_drain("reset_mid_even", n0, 0);
        n0 = pulse_cyc.size();
        fill(24'h0, 1'b1); send_line(4, 1'b0, 0);
        check_drain("reset_mid_odd", n0, 2);
    endtask

    task automatic test_half_depth();
        int n0;
        n0 = pulse_cyc.size();
        en1 = 1'b1;
        pix1 = 12'h123;
        fill(24'h102030, 1'b0);
        send_line(4, 1'b1, 0);
        send_line(4, 1'b0, 0);
        check_drain("half_depth", n0, 2);
        en1 = 1'b0;
        pix1 = 12'h0;
    endtask

    initial begin
        test_reset();
        test_flat();
        test_rounding();
        test_back_to_back();
        test_line_len();
        test_frame_restart();
        test_reset_mid();
        test_half_depth();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
